// File: rtl/decode_stage_pipe_pkg.sv
// Shared widths, opcode map, scoreboard entry type and default parameters
// for the registered decode stage.
package decode_stage_pipe_pkg;

    localparam int ALU_OP_BITS = 4;
    localparam int ALU_FN_BITS = 5;
    localparam int SEL_BITS    = 2;

    localparam int DEF_DBITS               = 32;
    localparam int DEF_REG_INDEX_BIT_WIDTH = 4;
    localparam int DEF_IMM_BITS            = 16;
    localparam int DEF_SB_DEPTH            = 3;
    localparam int DEF_STALL_CNT_BITS      = 16;

    // Scoreboard entries carry a fixed-width dest; narrower register
    // indices are zero-extended so the struct stays unparametrised.
    localparam int SB_DEST_BITS = 8;

    typedef struct packed {
        logic                    valid;
        logic [SB_DEST_BITS-1:0] dest;
    } sb_entry_t;

    typedef enum logic [ALU_OP_BITS-1:0] {
        OP_ALUR   = 4'h0,
        OP_ALUI   = 4'h1,
        OP_LUI    = 4'h2,
        OP_LOAD   = 4'h4,
        OP_STORE  = 4'h5,
        OP_BRANCH = 4'h6,
        OP_JAL    = 4'h7
    } opcode_t;

    localparam logic [SEL_BITS-1:0] SR2_REG   = 2'd0;
    localparam logic [SEL_BITS-1:0] SR2_IMM   = 2'd1;
    localparam logic [SEL_BITS-1:0] SR2_IMMHI = 2'd2;
    localparam logic [SEL_BITS-1:0] DIN_ALU   = 2'd0;
    localparam logic [SEL_BITS-1:0] DIN_MEM   = 2'd1;
    localparam logic [SEL_BITS-1:0] DIN_PC    = 2'd2;

    localparam logic [ALU_FN_BITS-1:0] FN_ADD = 5'h00;
    localparam logic [ALU_FN_BITS-1:0] FN_SUB = 5'h08;

endpackage

// File: rtl/decode_stage_pipe_decoder.sv
// Combinational instruction decoder.
// Layout (MSB first): opcode | dest | src1 | src2 | ... | imm[IMM_BITS-1:0].
module Decoder
    import decode_stage_pipe_pkg::*;
#(
    parameter int DBITS               = DEF_DBITS,
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
    parameter int IMM_BITS            = DEF_IMM_BITS
) (
    input  logic [DBITS-1:0]               inst_word,
    output logic [ALU_OP_BITS-1:0]         alu_op,
    output logic [ALU_FN_BITS-1:0]         alu_fn,
    output logic [REG_INDEX_BIT_WIDTH-1:0] src_reg1_addr,
    output logic [REG_INDEX_BIT_WIDTH-1:0] src_reg2_addr,
    output logic [REG_INDEX_BIT_WIDTH-1:0] dest_reg_addr,
    output logic [SEL_BITS-1:0]            sel_alu_sr2,
    output logic [SEL_BITS-1:0]            sel_reg_din,
    output logic                           wr_reg,
    output logic                           wr_mem,
    output logic [IMM_BITS-1:0]            imm
);
    localparam int RW = REG_INDEX_BIT_WIDTH;

    assign alu_op        = inst_word[DBITS-1 -: ALU_OP_BITS];
    assign dest_reg_addr = inst_word[DBITS-ALU_OP_BITS-1 -: RW];
    assign src_reg1_addr = inst_word[DBITS-ALU_OP_BITS-RW-1 -: RW];
    assign src_reg2_addr = inst_word[DBITS-ALU_OP_BITS-2*RW-1 -: RW];
    assign imm           = inst_word[IMM_BITS-1:0];

    // Control fields per opcode; unknown opcodes decode as a no-op.
    always_comb begin
        alu_fn      = FN_ADD;
        sel_alu_sr2 = SR2_REG;
        sel_reg_din = DIN_ALU;
        wr_reg      = 1'b0;
        wr_mem      = 1'b0;
        case (alu_op)
            OP_ALUR:   begin alu_fn = imm[ALU_FN_BITS-1:0]; wr_reg = 1'b1; end
            OP_ALUI:   begin sel_alu_sr2 = SR2_IMM;   wr_reg = 1'b1; end
            OP_LUI:    begin sel_alu_sr2 = SR2_IMMHI; wr_reg = 1'b1; end
            OP_LOAD:   begin sel_alu_sr2 = SR2_IMM; sel_reg_din = DIN_MEM; wr_reg = 1'b1; end
            OP_STORE:  begin sel_alu_sr2 = SR2_IMM; wr_mem = 1'b1; end
            OP_BRANCH: begin alu_fn = FN_SUB; end
            OP_JAL:    begin sel_alu_sr2 = SR2_IMM; sel_reg_din = DIN_PC; wr_reg = 1'b1; end
            default:   ;
        endcase
    end
endmodule

// File: rtl/decode_stage_pipe_raw_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers plus the
// RAW comparators against the instruction being decoded.
module raw_scoreboard
    import decode_stage_pipe_pkg::*;
#(
    parameter int SB_DEPTH            = DEF_SB_DEPTH,
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           shift,
    input  logic                           push_valid,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] push_dest,
    input  logic                           head_valid,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] head_dest,
    input  logic                           req,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] src1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] src2,
    output logic                           hazard
);
    sb_entry_t               sb_reg [SB_DEPTH];
    logic [SB_DEPTH-1:0]     match;
    logic                    head_match;
    logic [SB_DEST_BITS-1:0] src1_ext;
    logic [SB_DEST_BITS-1:0] src2_ext;

    assign src1_ext = SB_DEST_BITS'(src1);
    assign src2_ext = SB_DEST_BITS'(src2);

    // Entry 0 is the youngest; the oldest falls off the end on each shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SB_DEPTH; i++) sb_reg[i] <= '0;
        end else if (shift) begin
            for (int i = SB_DEPTH-1; i > 0; i--) sb_reg[i] <= sb_reg[i-1];
            sb_reg[0] <= '{valid: push_valid, dest: SB_DEST_BITS'(push_dest)};
        end
    end

    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_cmp
            assign match[gi] = sb_reg[gi].valid &
                               ((sb_reg[gi].dest == src1_ext) | (sb_reg[gi].dest == src2_ext));
        end
    endgenerate

    // Both sources are compared unconditionally, which is conservative.
    assign head_match = head_valid & ((head_dest == src1) | (head_dest == src2));
    assign hazard     = req & (head_match | (|match));
endmodule

// File: rtl/decode_stage_pipe.sv
// Registered decode stage: valid/ready handshake from fetch, decoder,
// output pipeline register, RAW stall via scoreboard, stall counter.
module decode_stage_pipe
    import decode_stage_pipe_pkg::*;
#(
    parameter int DBITS               = DEF_DBITS,
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
    parameter int IMM_BITS            = DEF_IMM_BITS,
    parameter int SB_DEPTH            = DEF_SB_DEPTH,
    parameter int STALL_CNT_BITS      = DEF_STALL_CNT_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DBITS-1:0]               inst_word,
    input  logic [DBITS-1:0]               pc_in,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ALU_OP_BITS-1:0]         alu_op,
    output logic [ALU_FN_BITS-1:0]         alu_fn,
    output logic [REG_INDEX_BIT_WIDTH-1:0] src_reg1_addr,
    output logic [REG_INDEX_BIT_WIDTH-1:0] src_reg2_addr,
    output logic [REG_INDEX_BIT_WIDTH-1:0] dest_reg_addr,
    output logic [SEL_BITS-1:0]            sel_alu_sr2,
    output logic [SEL_BITS-1:0]            sel_reg_din,
    output logic                           wr_reg,
    output logic                           wr_mem,
    output logic [DBITS-1:0]               imm_ext,
    output logic [DBITS-1:0]               imm_hi,
    output logic [DBITS-1:0]               pc_out,
    output logic [STALL_CNT_BITS-1:0]      stall_count
);
    localparam int RW  = REG_INDEX_BIT_WIDTH;
    localparam int EXT = DBITS - IMM_BITS;

    logic [ALU_OP_BITS-1:0] dec_alu_op;
    logic [ALU_FN_BITS-1:0] dec_alu_fn;
    logic [RW-1:0]          dec_src1, dec_src2, dec_dest;
    logic [SEL_BITS-1:0]    dec_sel_sr2, dec_sel_din;
    logic                   dec_wr_reg, dec_wr_mem;
    logic [IMM_BITS-1:0]    dec_imm;

    logic                   out_valid_reg;
    logic [ALU_OP_BITS-1:0] alu_op_reg;
    logic [ALU_FN_BITS-1:0] alu_fn_reg;
    logic [RW-1:0]          src1_reg, src2_reg, dest_reg;
    logic [SEL_BITS-1:0]    sel_sr2_reg, sel_din_reg;
    logic                   wr_reg_reg, wr_mem_reg;
    logic [IMM_BITS-1:0]    imm_reg;
    logic [DBITS-1:0]       pc_reg;
    logic [STALL_CNT_BITS-1:0] stall_count_reg;

    logic hazard, advance, fire, stall_event;

    Decoder #(
        .DBITS(DBITS), .REG_INDEX_BIT_WIDTH(RW), .IMM_BITS(IMM_BITS)
    ) u_decoder (
        .inst_word(inst_word), .alu_op(dec_alu_op), .alu_fn(dec_alu_fn),
        .src_reg1_addr(dec_src1), .src_reg2_addr(dec_src2), .dest_reg_addr(dec_dest),
        .sel_alu_sr2(dec_sel_sr2), .sel_reg_din(dec_sel_din),
        .wr_reg(dec_wr_reg), .wr_mem(dec_wr_mem), .imm(dec_imm)
    );

    // A flushed output entry is pushed as invalid; older entries stay real.
    raw_scoreboard #(
        .SB_DEPTH(SB_DEPTH), .REG_INDEX_BIT_WIDTH(RW)
    ) u_raw_scoreboard (
        .clk(clk), .reset(reset), .shift(out_ready),
        .push_valid(out_valid_reg & wr_reg_reg & ~flush), .push_dest(dest_reg),
        .head_valid(out_valid_reg & wr_reg_reg), .head_dest(dest_reg),
        .req(in_valid), .src1(dec_src1), .src2(dec_src2), .hazard(hazard)
    );

    assign advance     = ~out_valid_reg | out_ready;
    assign in_ready    = ~hazard & ~flush & advance;
    assign fire        = in_valid & in_ready;
    assign stall_event = in_valid & hazard & advance;

    // Output-register occupancy: set on fire, drained by execute or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     out_valid_reg <= 1'b0;
        else if (fire)                  out_valid_reg <= 1'b1;
        else if (out_ready || flush)    out_valid_reg <= 1'b0;
    end

    // Field registers load only on fire and otherwise keep stale values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_op_reg <= '0; alu_fn_reg <= '0; src1_reg <= '0; src2_reg <= '0;
            dest_reg <= '0; sel_sr2_reg <= '0; sel_din_reg <= '0;
            wr_reg_reg <= 1'b0; wr_mem_reg <= 1'b0; imm_reg <= '0; pc_reg <= '0;
        end else if (fire) begin
            alu_op_reg <= dec_alu_op; alu_fn_reg <= dec_alu_fn; src1_reg <= dec_src1;
            src2_reg <= dec_src2; dest_reg <= dec_dest; sel_sr2_reg <= dec_sel_sr2;
            sel_din_reg <= dec_sel_din; wr_reg_reg <= dec_wr_reg; wr_mem_reg <= dec_wr_mem;
            imm_reg <= dec_imm; pc_reg <= pc_in;
        end
    end

    // Saturating count of cycles lost to RAW hazards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                      stall_count_reg <= '0;
        else if (stall_event && (stall_count_reg != '1)) stall_count_reg <= stall_count_reg + 1'b1;
    end

    assign out_valid     = out_valid_reg;
    assign alu_op        = alu_op_reg;
    assign alu_fn        = alu_fn_reg;
    assign src_reg1_addr = src1_reg;
    assign src_reg2_addr = src2_reg;
    assign dest_reg_addr = dest_reg;
    assign sel_alu_sr2   = sel_sr2_reg;
    assign sel_reg_din   = sel_din_reg;
    assign wr_reg        = wr_reg_reg;
    assign wr_mem        = wr_mem_reg;
    assign pc_out        = pc_reg;
    assign stall_count   = stall_count_reg;
    assign imm_ext       = {{EXT{imm_reg[IMM_BITS-1]}}, imm_reg};
    assign imm_hi        = {imm_reg, {EXT{1'b0}}};
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe (default parameters).
module tb_decode_stage_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] inst_word, pc_in, imm_ext, imm_hi, pc_out;
    logic [3:0]  alu_op, src_reg1_addr, src_reg2_addr, dest_reg_addr;
    logic [4:0]  alu_fn;
    logic [1:0]  sel_alu_sr2, sel_reg_din;
    logic        wr_reg, wr_mem;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .inst_word(inst_word), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_op(alu_op), .alu_fn(alu_fn),
        .src_reg1_addr(src_reg1_addr), .src_reg2_addr(src_reg2_addr),
        .dest_reg_addr(dest_reg_addr), .sel_alu_sr2(sel_alu_sr2),
        .sel_reg_din(sel_reg_din), .wr_reg(wr_reg), .wr_mem(wr_mem),
        .imm_ext(imm_ext), .imm_hi(imm_hi), .pc_out(pc_out), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h (t=%0t)", tag, got, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] d,
                                        input logic [3:0] s1, input logic [3:0] s2,
                                        input logic [15:0] imm);
        return {op, d, s1, s2, imm};
    endfunction

    // Hand table: {alu_fn, sel_alu_sr2, sel_reg_din, wr_reg, wr_mem}
    function automatic logic [10:0] exp_ctrl(input logic [3:0] op, input logic [15:0] imm);
        case (op)
            4'h0:    return {imm[4:0], 2'd0, 2'd0, 1'b1, 1'b0};
            4'h1:    return {5'h00, 2'd1, 2'd0, 1'b1, 1'b0};
            4'h2:    return {5'h00, 2'd2, 2'd0, 1'b1, 1'b0};
            4'h4:    return {5'h00, 2'd1, 2'd1, 1'b1, 1'b0};
            4'h5:    return {5'h00, 2'd1, 2'd0, 1'b0, 1'b1};
            4'h6:    return {5'h08, 2'd0, 2'd0, 1'b0, 1'b0};
            4'h7:    return {5'h00, 2'd1, 2'd2, 1'b1, 1'b0};
            default: return 11'd0;
        endcase
    endfunction

    task automatic check_out(input string tag, input logic [3:0] op, input logic [3:0] d,
                             input logic [3:0] s1, input logic [3:0] s2,
                             input logic [15:0] imm, input logic [31:0] pc);
        logic [10:0] c;
        c = exp_ctrl(op, imm);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_alu_op"}, alu_op, op);
        check({tag, "_dest"}, dest_reg_addr, d);
        check({tag, "_src1"}, src_reg1_addr, s1);
        check({tag, "_src2"}, src_reg2_addr, s2);
        check({tag, "_ctrl"}, {alu_fn, sel_alu_sr2, sel_reg_din, wr_reg, wr_mem}, c);
        check({tag, "_pc"}, pc_out, pc);
        check({tag, "_imm_ext"}, imm_ext, {{16{imm[15]}}, imm});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] w, input logic [31:0] pc);
        in_valid  = 1'b1;
        inst_word = w;
        pc_in     = pc;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [3:0]  tp_op  [8];
    logic [15:0] tp_imm [8];

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        inst_word = '0; pc_in = '0;
        tp_op = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h7, 4'h0, 4'h1, 4'h4};
        repeat (2) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_stall_count", stall_count, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_imm_ext", imm_ext, 0);
        reset = 1'b1;

        // Throughput: 8 independent instructions, dests r1..r8, sources r9..r15
        for (int t = 0; t <= 8; t++) begin
            if (t < 8) begin
                tp_imm[t] = 16'h0101 * 16'(t) + 16'h0013;
                present(enc(tp_op[t], 4'(t + 1), 4'(9 + t % 4), 4'(13 + t % 3), tp_imm[t]),
                        32'h1000 + 32'(4 * t));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (t < 8) check("tp_in_ready", in_ready, 1);
            if (t > 0)
                check_out("tp", tp_op[t-1], 4'(t), 4'(9 + (t-1) % 4), 4'(13 + (t-1) % 3),
                          tp_imm[t-1], 32'h1000 + 32'(4 * (t-1)));
            step();
        end
        @(negedge clk);
        check("tp_drained", out_valid, 0);
        check("tp_stall_count", stall_count, 0);
        drain();

        // RAW: producer writes r3, consumer reads r3 right behind it
        present(enc(4'h1, 4'd3, 4'd9, 4'd10, 16'h0005), 32'h2000);
        @(negedge clk); check("raw_prod_ready", in_ready, 1); step();
        present(enc(4'h0, 4'd4, 4'd3, 4'd10, 16'h0001), 32'h2004);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("raw_stall", in_ready, 0); step();
        end
        @(negedge clk);
        check("raw_accept", in_ready, 1);
        check("raw_stall_count", stall_count, 4);
        step();
        in_valid = 1'b0;
        @(negedge clk); check_out("raw_cons", 4'h0, 4'd4, 4'd3, 4'd10, 16'h0001, 32'h2004);
        drain();

        // Backpressure: R (writes r6) held 5 cycles, dependent S waiting
        present(enc(4'h1, 4'd6, 4'd9, 4'd10, 16'h0022), 32'h3000);
        @(negedge clk); check("bp_r_ready", in_ready, 1); step();
        out_ready = 1'b0;
        present(enc(4'h0, 4'd8, 4'd6, 4'd11, 16'h0003), 32'h3004);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_pc_hold", pc_out, 32'h3000);
            check("bp_dest_hold", dest_reg_addr, 6);
            check("bp_stall_hold", stall_count, 4);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("bp_dep_stall", in_ready, 0); step();
        end
        @(negedge clk);
        check("bp_dep_accept", in_ready, 1);
        check("bp_stall_count", stall_count, 8);
        step();
        in_valid = 1'b0;
        @(negedge clk); check_out("bp_s", 4'h0, 4'd8, 4'd6, 4'd11, 16'h0003, 32'h3004);
        drain();

        // Flush: W writes r5, X flushed behind it, Y reads r5
        present(enc(4'h1, 4'd5, 4'd9, 4'd10, 16'h0000), 32'h4000);
        @(negedge clk); check("fl_w_ready", in_ready, 1); step();
        present(enc(4'h1, 4'd7, 4'd11, 4'd12, 16'h0000), 32'h4004);
        @(negedge clk); check("fl_x_ready", in_ready, 1); step();
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("fl_pre_valid", out_valid, 1);
        check("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        present(enc(4'h0, 4'd9, 4'd5, 4'd12, 16'h0000), 32'h4008);
        @(negedge clk); check("fl_killed", out_valid, 0); check("fl_y_stall0", in_ready, 0); step();
        @(negedge clk); check("fl_y_stall1", in_ready, 0); step();
        @(negedge clk); check("fl_y_accept", in_ready, 1); check("fl_stall_count", stall_count, 10);
        step();
        in_valid = 1'b0;
        @(negedge clk); check_out("fl_y", 4'h0, 4'd9, 4'd5, 4'd12, 16'h0000, 32'h4008);
        drain();

        // Immediates
        present(enc(4'h1, 4'd1, 4'd9, 4'd10, 16'h8000), 32'h5000);
        step();
        present(enc(4'h1, 4'd2, 4'd9, 4'd10, 16'h7FFF), 32'h5004);
        @(negedge clk);
        check("imm_ext_neg", imm_ext, 32'hFFFF8000);
        check("imm_hi_neg", imm_hi, 32'h80000000);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("imm_ext_pos", imm_ext, 32'h00007FFF);
        check("imm_hi_pos", imm_hi, 32'h7FFF0000);
        drain();

        // Reset in the middle of a stall drops the held instruction and scoreboard
        present(enc(4'h1, 4'd2, 4'd9, 4'd10, 16'h0000), 32'h6000);
        step();
        present(enc(4'h0, 4'd3, 4'd2, 4'd9, 16'h0000), 32'h6004);
        #2;
        check("mr_stall", in_ready, 0);
        check("mr_held_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_pc_out", pc_out, 0);
        check("mr_stall_count", stall_count, 0);
        check("mr_alu_op", alu_op, 0);
        check("mr_wr_reg", wr_reg, 0);
        step();
        reset = 1'b1;
        @(negedge clk); check("mr_in_ready", in_ready, 1); step();
        in_valid = 1'b0;
        @(negedge clk); check_out("mr_c", 4'h0, 4'd3, 4'd2, 4'd9, 16'h0000, 32'h6004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
